// File: rtl/lcd_show_char_if.sv
// ---------------------------------------------------------------------------
// lcd_show_char_if
//
// Bundles the request, font ROM and lcd_write-side signals of the character
// renderer so that it and its surroundings can be connected with one port.
//
// Signals
//   init_done          LCD init finished; starts are ignored while low
//   start              one-cycle draw request
//   ascii_num          character code 0..127
//   start_x / start_y  top-left pixel position of the glyph
//   fg_color/bg_color  RGB565 colours for font bit 1 / 0
//   font_addr          font ROM address {ascii, font row}
//   font_q             font ROM row, bit 7 = leftmost pixel, 1-cycle latency
//   wr_done            lcd_write finished shifting the current word
//   show_char_data     {DC, byte} word towards lcd_write
//   en_write_show_char one-cycle strobe qualifying show_char_data
//   busy               glyph in progress
//   show_char_done     one-cycle pulse at the end of a glyph
//   range_err          one-cycle pulse when a start is rejected
//
// Modports
//   slave  : the character renderer itself
//   master : the environment (request source, font ROM, lcd_write)
// ---------------------------------------------------------------------------
interface lcd_show_char_if;
  logic        init_done;
  logic        start;
  logic [6:0]  ascii_num;
  logic [8:0]  start_x;
  logic [8:0]  start_y;
  logic [15:0] fg_color;
  logic [15:0] bg_color;
  logic [10:0] font_addr;
  logic [7:0]  font_q;
  logic        wr_done;
  logic [8:0]  show_char_data;
  logic        en_write_show_char;
  logic        busy;
  logic        show_char_done;
  logic        range_err;

  modport slave (
    input  init_done, start, ascii_num, start_x, start_y, fg_color, bg_color,
           font_q, wr_done,
    output font_addr, show_char_data, en_write_show_char, busy,
           show_char_done, range_err
  );

  modport master (
    output init_done, start, ascii_num, start_x, start_y, fg_color, bg_color,
           font_q, wr_done,
    input  font_addr, show_char_data, en_write_show_char, busy,
           show_char_done, range_err
  );
endinterface

// File: rtl/lcd_show_char.sv
// ---------------------------------------------------------------------------
// lcd_show_char
//
// Draws one ASCII glyph on the SPI LCD: programs the column/row window
// (0x2A/0x2B), issues RAM write (0x2C) and then streams one RGB565 pixel per
// glyph cell, fetched row by row from an external synchronous font ROM.
// Words go to lcd_write one at a time; each word is strobed once and held
// until lcd_write reports wr_done.
//
// Ports
//   sys_clk  single 50 MHz clock
//   sys_rst  asynchronous, active-high reset
//   bus      lcd_show_char_if.slave (request, font ROM, lcd_write signals)
//
// Parameters
//   X_MAX, Y_MAX  last valid column / row of the panel
//   DATA_IDLE     value of show_char_data when no word is pending
//
// Configuration macro
//   LCD_CHAR_SCALE2_EN  when defined, each font bit is replicated 2x2
//                       (16x32 glyph); when undefined the glyph is 8x16.
// ---------------------------------------------------------------------------
module lcd_show_char #(
  parameter logic [8:0] X_MAX     = 9'd239,
  parameter logic [8:0] Y_MAX     = 9'd319,
  parameter logic [8:0] DATA_IDLE = 9'b0_0000_0000
) (
  input logic            sys_clk,
  input logic            sys_rst,
  lcd_show_char_if.slave bus
);

`ifdef LCD_CHAR_SCALE2_EN
  localparam int W     = 16;
  localparam int H     = 32;
  localparam int COL_W = 4;
  localparam int ROW_W = 5;
`else
  localparam int W     = 8;
  localparam int H     = 16;
  localparam int COL_W = 3;
  localparam int ROW_W = 4;
`endif

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);
  localparam logic [3:0]       SEQ_LAST = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEQ,
    S_FETCH,
    S_PIX,
    S_DONE
  } stateT;

  stateT            state_q, state_d;
  logic [3:0]       wordIdx_q, wordIdx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             byteSel_q, byteSel_d;
  logic             fetchPhase_q, fetchPhase_d;
  logic             sent_q, sent_d;
  logic [7:0]       rowBits_q, rowBits_d;
  logic [6:0]       ascii_q, ascii_d;
  logic [8:0]       xStart_q, xStart_d;
  logic [8:0]       yStart_q, yStart_d;
  logic [15:0]      fgColor_q, fgColor_d;
  logic [15:0]      bgColor_q, bgColor_d;
  logic             rangeErr_q, rangeErr_d;

  logic [9:0]       xEndWide, yEndWide;
  logic             rangeBad;
  logic [15:0]      xs, xe, ys, ye;
  logic [3:0]       fontRow;
  logic [2:0]       bitIdx;
  logic [15:0]      pixColor;
  logic [8:0]       seqWord, pixWord;
  logic [8:0]       dataOut;
  logic             enOut;
  logic             doneOut;

  // The end coordinates of a requested glyph are formed one bit wider than
  // the inputs so that a start near 511 cannot wrap and slip past the check.
  assign xEndWide = {1'b0, bus.start_x} + 10'(W - 1);
  assign yEndWide = {1'b0, bus.start_y} + 10'(H - 1);
  assign rangeBad = (xEndWide > {1'b0, X_MAX}) || (yEndWide > {1'b0, Y_MAX});

  assign xs = {7'd0, xStart_q};
  assign ys = {7'd0, yStart_q};
  assign xe = xs + 16'(W - 1);
  assign ye = ys + 16'(H - 1);

  // Display row/column map onto font row/bit; in the scaled build each font
  // cell covers two display rows and two display columns.
`ifdef LCD_CHAR_SCALE2_EN
  assign fontRow = row_q[4:1];
  assign bitIdx  = 3'd7 - col_q[3:1];
`else
  assign fontRow = row_q;
  assign bitIdx  = 3'd7 - col_q;
`endif

  assign pixColor = rowBits_q[bitIdx] ? fgColor_q : bgColor_q;
  assign pixWord  = byteSel_q ? {1'b1, pixColor[7:0]} : {1'b1, pixColor[15:8]};

  // Window setup sequence: column window, row window, then RAM write.
  always_comb begin
    seqWord = DATA_IDLE;
    case (wordIdx_q)
      4'd0:    seqWord = {1'b0, 8'h2A};
      4'd1:    seqWord = {1'b1, xs[15:8]};
      4'd2:    seqWord = {1'b1, xs[7:0]};
      4'd3:    seqWord = {1'b1, xe[15:8]};
      4'd4:    seqWord = {1'b1, xe[7:0]};
      4'd5:    seqWord = {1'b0, 8'h2B};
      4'd6:    seqWord = {1'b1, ys[15:8]};
      4'd7:    seqWord = {1'b1, ys[7:0]};
      4'd8:    seqWord = {1'b1, ye[15:8]};
      4'd9:    seqWord = {1'b1, ye[7:0]};
      4'd10:   seqWord = {1'b0, 8'h2C};
      default: seqWord = DATA_IDLE;
    endcase
  end

  // Next-state and output logic. sent_q marks that the current word has
  // already been strobed, so the strobe lasts exactly one cycle while the
  // word itself stays on show_char_data until wr_done. A wr_done in the
  // strobe cycle completes the word straight away.
  always_comb begin
    state_d      = state_q;
    wordIdx_d    = wordIdx_q;
    col_d        = col_q;
    row_d        = row_q;
    byteSel_d    = byteSel_q;
    fetchPhase_d = fetchPhase_q;
    sent_d       = sent_q;
    rowBits_d    = rowBits_q;
    ascii_d      = ascii_q;
    xStart_d     = xStart_q;
    yStart_d     = yStart_q;
    fgColor_d    = fgColor_q;
    bgColor_d    = bgColor_q;
    rangeErr_d   = 1'b0;
    dataOut      = DATA_IDLE;
    enOut        = 1'b0;
    doneOut      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && bus.init_done) begin
          ascii_d   = bus.ascii_num;
          xStart_d  = bus.start_x;
          yStart_d  = bus.start_y;
          fgColor_d = bus.fg_color;
          bgColor_d = bus.bg_color;
          if (rangeBad) begin
            rangeErr_d = 1'b1;
          end else begin
            state_d      = S_SEQ;
            wordIdx_d    = 4'd0;
            col_d        = '0;
            row_d        = '0;
            byteSel_d    = 1'b0;
            fetchPhase_d = 1'b0;
            sent_d       = 1'b0;
          end
        end
      end

      S_SEQ: begin
        dataOut = seqWord;
        if (!sent_q) begin
          enOut  = 1'b1;
          sent_d = 1'b1;
        end
        if (bus.wr_done) begin
          sent_d = 1'b0;
          if (wordIdx_q == SEQ_LAST) begin
            state_d      = S_FETCH;
            fetchPhase_d = 1'b0;
          end else begin
            wordIdx_d = wordIdx_q + 4'd1;
          end
        end
      end

      // First cycle presents the address, second captures the ROM output.
      S_FETCH: begin
        if (!fetchPhase_q) begin
          fetchPhase_d = 1'b1;
        end else begin
          rowBits_d    = bus.font_q;
          fetchPhase_d = 1'b0;
          state_d      = S_PIX;
          sent_d       = 1'b0;
          byteSel_d    = 1'b0;
          col_d        = '0;
        end
      end

      S_PIX: begin
        dataOut = pixWord;
        if (!sent_q) begin
          enOut  = 1'b1;
          sent_d = 1'b1;
        end
        if (bus.wr_done) begin
          sent_d = 1'b0;
          if (!byteSel_q) begin
            byteSel_d = 1'b1;
          end else begin
            byteSel_d = 1'b0;
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                state_d = S_DONE;
              end else begin
                row_d   = row_q + 1'b1;
                state_d = S_FETCH;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        doneOut = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any glyph immediately.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      wordIdx_q    <= '0;
      col_q        <= '0;
      row_q        <= '0;
      byteSel_q    <= 1'b0;
      fetchPhase_q <= 1'b0;
      sent_q       <= 1'b0;
      rowBits_q    <= '0;
      ascii_q      <= '0;
      xStart_q     <= '0;
      yStart_q     <= '0;
      fgColor_q    <= '0;
      bgColor_q    <= '0;
      rangeErr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wordIdx_q    <= wordIdx_d;
      col_q        <= col_d;
      row_q        <= row_d;
      byteSel_q    <= byteSel_d;
      fetchPhase_q <= fetchPhase_d;
      sent_q       <= sent_d;
      rowBits_q    <= rowBits_d;
      ascii_q      <= ascii_d;
      xStart_q     <= xStart_d;
      yStart_q     <= yStart_d;
      fgColor_q    <= fgColor_d;
      bgColor_q    <= bgColor_d;
      rangeErr_q   <= rangeErr_d;
    end
  end

  assign bus.font_addr          = {ascii_q, fontRow};
  assign bus.show_char_data     = dataOut;
  assign bus.en_write_show_char = enOut;
  assign bus.busy               = (state_q == S_SEQ) || (state_q == S_FETCH) ||
                                  (state_q == S_PIX);
  assign bus.show_char_done     = doneOut;
  assign bus.range_err          = rangeErr_q;

endmodule

// File: tb/tb_lcd_show_char.sv
// ---------------------------------------------------------------------------
// tb_lcd_show_char
//
// Bench for lcd_show_char. A random font ROM with one cycle of latency and a
// wr_done responder stand in for the surroundings; expected word streams and
// font addresses are derived from glyph geometry with plain arithmetic.
// Follows LCD_CHAR_SCALE2_EN so it matches whichever build it is paired with.
// ---------------------------------------------------------------------------
module tb_lcd_show_char;

  localparam int         X_MAX     = 239;
  localparam int         Y_MAX     = 319;
  localparam logic [8:0] DATA_IDLE = 9'h000;
`ifdef LCD_CHAR_SCALE2_EN
  localparam int W = 16;
  localparam int H = 32;
`else
  localparam int W = 8;
  localparam int H = 16;
`endif

  logic clk = 1'b0;
  logic rst;

  lcd_show_char_if bus ();

  lcd_show_char #(
    .X_MAX    (9'(X_MAX)),
    .Y_MAX    (9'(Y_MAX)),
    .DATA_IDLE(DATA_IDLE)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Font ROM with one cycle of read latency.
  logic [7:0] rom [0:2047];
  always @(posedge clk) bus.font_q <= rom[bus.font_addr];

  logic [8:0]  wordQ[$];
  logic [8:0]  expQ[$];
  int          enCycQ[$];
  int          doneCycQ[$];
  logic [10:0] addrQ[$];
  logic [10:0] expAddrQ[$];
  int          doneCount, busyAtDone, rangeCount, rangeCyc, doneCyc, holdErrs;
  int          startCyc;
  bit          busySeen;
  int          countdown = -1;
  int          doneDelay = 5;
  bit          outstanding;
  logic [8:0]  lastWord;
  int          strayCount = 0;
  int          strayServed = 0;
  int          compared = 0;
  int          mismatched = 0;

  // Observes the DUT away from the active edge and answers every strobe
  // with wr_done after doneDelay cycles (random 0..6 when negative).
  always @(negedge clk) begin
    if (rst) begin
      bus.wr_done = 1'b0;
      countdown   = -1;
      outstanding = 1'b0;
    end else begin
      if (outstanding && bus.show_char_data !== lastWord) holdErrs++;
      if (!outstanding && !bus.en_write_show_char && bus.show_char_data !== DATA_IDLE)
        holdErrs++;
      if (bus.en_write_show_char) begin
        wordQ.push_back(bus.show_char_data);
        enCycQ.push_back(cyc);
        outstanding = 1'b1;
        lastWord    = bus.show_char_data;
      end
      if (bus.busy) busySeen = 1'b1;
      if (bus.show_char_done) begin
        doneCount++;
        doneCyc = cyc;
        if (bus.busy) busyAtDone++;
      end
      if (bus.range_err) begin
        rangeCount++;
        rangeCyc = cyc;
      end
      if (bus.busy && (addrQ.size() == 0 || addrQ[$] !== bus.font_addr))
        addrQ.push_back(bus.font_addr);

      bus.wr_done = 1'b0;
      if (strayServed != strayCount) begin
        bus.wr_done = 1'b1;
        strayServed = strayCount;
      end
      if (bus.en_write_show_char)
        countdown = (doneDelay < 0) ? int'($urandom_range(6, 0)) : doneDelay;
      if (countdown == 0) begin
        bus.wr_done = 1'b1;
        countdown   = -1;
        outstanding = 1'b0;
        doneCycQ.push_back(cyc);
      end else if (countdown > 0) begin
        countdown--;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearCapture();
    wordQ.delete();
    enCycQ.delete();
    doneCycQ.delete();
    addrQ.delete();
    doneCount  = 0;
    busyAtDone = 0;
    rangeCount = 0;
    rangeCyc   = -100;
    doneCyc    = -100;
    holdErrs   = 0;
    busySeen   = 1'b0;
  endtask

  // Expected glyph stream: window words, RAM write, then each display cell
  // coloured from the font bit it maps onto.
  task automatic buildExpected(input int ascii, input int x, input int y,
                               input int fg, input int bg);
    int xe, ye, fr, fb, rb, color;
    xe = x + W - 1;
    ye = y + H - 1;
    expQ.delete();
    expAddrQ.delete();
    expQ.push_back(9'h02A);
    expQ.push_back(9'(256 + x / 256));
    expQ.push_back(9'(256 + x % 256));
    expQ.push_back(9'(256 + xe / 256));
    expQ.push_back(9'(256 + xe % 256));
    expQ.push_back(9'h02B);
    expQ.push_back(9'(256 + y / 256));
    expQ.push_back(9'(256 + y % 256));
    expQ.push_back(9'(256 + ye / 256));
    expQ.push_back(9'(256 + ye % 256));
    expQ.push_back(9'h02C);
    for (int r = 0; r < 16; r++) expAddrQ.push_back(11'(ascii * 16 + r));
    for (int dr = 0; dr < H; dr++) begin
      fr = dr * 16 / H;
      rb = int'(rom[ascii * 16 + fr]);
      for (int dc = 0; dc < W; dc++) begin
        fb    = 7 - dc * 8 / W;
        color = ((rb >> fb) & 1) != 0 ? fg : bg;
        expQ.push_back(9'(256 + color / 256));
        expQ.push_back(9'(256 + color % 256));
      end
    end
  endtask

  task automatic applyStimulus(input int ascii, input int x, input int y,
                               input int fg, input int bg);
    @(negedge clk);
    bus.ascii_num = 7'(ascii);
    bus.start_x   = 9'(x);
    bus.start_y   = 9'(y);
    bus.fg_color  = 16'(fg);
    bus.bg_color  = 16'(bg);
    bus.start     = 1'b1;
    startCyc      = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // midMode 1: extra start while busy; midMode 2: init_done drops mid-glyph.
  task automatic runGlyph(input int ascii, input int x, input int y,
                          input int fg, input int bg, input int midMode);
    int timedOut, errs, timingErrs, gap, lastDone;
    buildExpected(ascii, x, y, fg, bg);
    clearCapture();
    applyStimulus(ascii, x, y, fg, bg);
    timedOut = 1;
    for (int k = 0; k < 30000; k++) begin
      @(negedge clk);
      if (doneCount > 0) begin
        timedOut = 0;
        break;
      end
      if (k == 60 && midMode == 1) begin
        bus.ascii_num = 7'h01;
        bus.start_x   = 9'd40;
        bus.start     = 1'b1;
      end
      if (k == 61) bus.start = 1'b0;
      if (k == 60 && midMode == 2) bus.init_done = 1'b0;
    end
    bus.start     = 1'b0;
    bus.init_done = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("doneTimeout", timedOut, 0);
    checkOutput("wordCount", wordQ.size(), 11 + 2 * W * H);
    errs = 0;
    for (int i = 0; i < wordQ.size() && i < expQ.size(); i++)
      if (wordQ[i] !== expQ[i]) errs++;
    checkOutput("wordData", errs, 0);
    checkOutput("doneCount", doneCount, 1);
    checkOutput("busyAtDone", busyAtDone, 0);
    checkOutput("wordHold", holdErrs, 0);
    checkOutput("rangeErrQuiet", rangeCount, 0);
    checkOutput("firstEnLatency", enCycQ.size() > 0 ? enCycQ[0] - startCyc : -1, 1);
    timingErrs = 0;
    for (int i = 0; i + 1 < enCycQ.size(); i++) begin
      gap = (i >= 10 && (i - 10) % (2 * W) == 0) ? 3 : 1;
      if (i >= doneCycQ.size() || enCycQ[i + 1] != doneCycQ[i] + gap) timingErrs++;
    end
    checkOutput("wordTiming", timingErrs, 0);
    lastDone = doneCycQ.size() > 0 ? doneCycQ[$] : -100;
    checkOutput("doneLatency", doneCyc - lastDone, 1);
    checkOutput("addrCount", addrQ.size(), 16);
    errs = 0;
    for (int i = 0; i < addrQ.size() && i < expAddrQ.size(); i++)
      if (addrQ[i] !== expAddrQ[i]) errs++;
    checkOutput("fontAddr", errs, 0);
  endtask

  task automatic runReject(input int x, input int y);
    clearCapture();
    applyStimulus(7'h41, x, y, 16'hFFFF, 16'h0000);
    repeat (30) @(negedge clk);
    checkOutput("rejectRangeErr", rangeCount, 1);
    checkOutput("rejectLatency", rangeCyc - startCyc, 1);
    checkOutput("rejectWords", wordQ.size(), 0);
    checkOutput("rejectBusy", busySeen, 0);
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, "Busy"}, 32'(bus.busy), 0);
    checkOutput({phase, "En"}, 32'(bus.en_write_show_char), 0);
    checkOutput({phase, "Data"}, 32'(bus.show_char_data), 32'(DATA_IDLE));
    checkOutput({phase, "Done"}, 32'(bus.show_char_done), 0);
    checkOutput({phase, "RangeErr"}, 32'(bus.range_err), 0);
    checkOutput({phase, "FontAddr"}, 32'(bus.font_addr), 0);
  endtask

  initial begin
    int rx, ry;
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rst           = 1'b1;
    bus.init_done = 1'b0;
    bus.start     = 1'b0;
    bus.ascii_num = '0;
    bus.start_x   = '0;
    bus.start_y   = '0;
    bus.fg_color  = '0;
    bus.bg_color  = '0;
    bus.wr_done   = 1'b0;
    clearCapture();

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] start with init_done low and stray wr_done in IDLE");
    clearCapture();
    applyStimulus(7'h41, 0, 0, 16'hF800, 16'h001F);
    strayCount++;
    repeat (30) @(negedge clk);
    checkOutput("noInitWords", wordQ.size(), 0);
    checkOutput("noInitBusy", busySeen, 0);
    checkOutput("noInitRangeErr", rangeCount, 0);
    bus.init_done = 1'b1;

    $display("[TB] basic glyph");
    doneDelay = 5;
    runGlyph(7'h41, 0, 0, 16'hF800, 16'h001F, 0);

    $display("[TB] range rejects");
    runReject(X_MAX - W + 2, 0);
    runReject(0, Y_MAX - H + 2);

    $display("[TB] right edge accepted");
    doneDelay = 2;
    runGlyph(7'h33, X_MAX - W + 1, 0, 16'h07E0, 16'h0000, 0);
    checkOutput("xeLowWord", wordQ.size() > 4 ? 32'(wordQ[4]) : 32'hFFFF_FFFF,
                32'(256 + (X_MAX % 256)));

    $display("[TB] glyph at (16,32)");
    runGlyph(7'h48, 16, 32, 16'h1234, 16'hABCD, 0);
    checkOutput("xeWord", wordQ.size() > 4 ? 32'(wordQ[4]) : 32'hFFFF_FFFF,
                32'(256 + 16 + W - 1));
    checkOutput("yeWord", wordQ.size() > 9 ? 32'(wordQ[9]) : 32'hFFFF_FFFF,
                32'(256 + 32 + H - 1));

    $display("[TB] start while busy, init_done drop mid-glyph");
    runGlyph(7'h7E, 100, Y_MAX - H + 1, 16'hFFFF, 16'h8410, 1);
    runGlyph(7'h20, 50, 60, 16'h0F0F, 16'hF0F0, 2);

    $display("[TB] reset mid-glyph");
    clearCapture();
    applyStimulus(7'h5A, 100, 200, 16'hFFE0, 16'h0010);
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (wordQ.size() >= 101) break;
    end
    checkOutput("rstReachedWord100", wordQ.size() >= 101, 1);
    rst = 1'b1;
    #1;
    checkResetOutputs("midReset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midResetNoDone", doneCount, 0);
    checkOutput("midResetIdle", 32'(bus.busy), 0);
    runGlyph(7'h5A, 100, 200, 16'hFFE0, 16'h0010, 0);

    $display("[TB] fast wr_done");
    doneDelay = 0;
    runGlyph(7'h61, 7, 9, 16'hC618, 16'h39E7, 0);

    $display("[TB] random glyphs");
    doneDelay = -1;
    for (int n = 0; n < 3; n++) begin
      rx = int'($urandom_range(X_MAX - W + 1, 0));
      ry = int'($urandom_range(Y_MAX - H + 1, 0));
      runGlyph(int'($urandom_range(127, 0)), rx, ry, int'($urandom_range(65535, 0)),
               int'($urandom_range(65535, 0)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
